// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch stage is the master: it issues a word address and receives data.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word at a time from
// instruction memory, presents it to decode until accepted, applies the
// taken-branch redirect and counts retired instructions.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master imem,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [31:0]  instr,
  output logic [31:0]  instr_pc,
  output logic [6:0]   op,
  input  logic         pc_src,
  input  logic [31:0]  pc_target,
  output logic [31:0]  instret
);

  typedef enum logic [1:0] {BOOT, ISSUE, WAIT, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] instr_pc_reg, instr_pc_next;
  logic [31:0] instret_reg, instret_next;
  logic        instr_valid_reg, instr_valid_next;

  // FSM state register; reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= BOOT;
    else        state_reg <= state_next;
  end

  // PC, held instruction and retirement counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg          <= RESET_PC;
      instr_reg       <= NOP_INSTR;
      instr_pc_reg    <= 32'h0000_0000;
      instret_reg     <= 32'h0000_0000;
      instr_valid_reg <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      instr_reg       <= instr_next;
      instr_pc_reg    <= instr_pc_next;
      instret_reg     <= instret_next;
      instr_valid_reg <= instr_valid_next;
    end
  end

  // Next-state and request logic; responses outside WAIT are dropped.
  always_comb begin
    state_next          = state_reg;
    pc_next             = pc_reg;
    instr_next          = instr_reg;
    instr_pc_next       = instr_pc_reg;
    instret_next        = instret_reg;
    instr_valid_next    = instr_valid_reg;
    imem.imem_req_valid = 1'b0;
    case (state_reg)
      BOOT: state_next = ISSUE;
      ISSUE: begin
        imem.imem_req_valid = 1'b1;
        if (imem.imem_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (imem.imem_rsp_valid) begin
          instr_next       = imem.imem_rsp_data;
          instr_pc_next    = pc_reg;
          instr_valid_next = 1'b1;
          state_next       = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          // Target low bits are dropped to keep fetches word aligned.
          pc_next          = pc_src ? {pc_target[31:2], 2'b00} : pc_reg + 32'd4;
          instret_next     = instret_reg + 32'd1;
          instr_valid_next = 1'b0;
          instr_next       = NOP_INSTR;
          state_next       = ISSUE;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  // The address is the PC itself, so it is stable for as long as ISSUE waits.
  assign imem.imem_addr = pc_reg;
  assign op             = instr_reg[6:0];
  assign instr          = instr_reg;
  assign instr_pc       = instr_pc_reg;
  assign instr_valid    = instr_valid_reg;
  assign instret        = instret_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed handshake scenarios, a randomized run
// against a transaction-level memory/retirement model, and a PC-wrap instance.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, rst1_n;
  fetch_unit_if bus0 ();
  fetch_unit_if bus1 ();
  logic        instr_valid, instr_ready, pc_src;
  logic [31:0] instr, instr_pc, pc_target, instret;
  logic [6:0]  op;
  logic        instr_valid1, instr_ready1, pc_src1;
  logic [31:0] instr1, instr_pc1, pc_target1, instret1;
  logic [6:0]  op1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc, exp_instret;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut0 (
    .clk(clk), .rst_n(rst_n), .imem(bus0),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .op(op), .pc_src(pc_src), .pc_target(pc_target),
    .instret(instret)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut1 (
    .clk(clk), .rst_n(rst1_n), .imem(bus1),
    .instr_valid(instr_valid1), .instr_ready(instr_ready1), .instr(instr1),
    .instr_pc(instr_pc1), .op(op1), .pc_src(pc_src1), .pc_target(pc_target1),
    .instret(instret1)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Holds reset for two edges, checks reset values (BOOT cycle), releases,
  // and returns at the negedge where the DUT is in ISSUE.
  task automatic do_reset0();
    rst_n = 1'b0;
    bus0.imem_req_ready = 1'b0; bus0.imem_rsp_valid = 1'b0; bus0.imem_rsp_data = 32'h0;
    instr_ready = 1'b0; pc_src = 1'b0; pc_target = 32'h0;
    @(negedge clk); @(negedge clk);
    chk("rst_ivalid", instr_valid, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_op", op, 32'h13);
    chk("rst_ipc", instr_pc, 0);
    chk("rst_instret", instret, 0);
    chk("rst_req", bus0.imem_req_valid, 0);
    chk("rst_addr", bus0.imem_addr, 0);
    rst_n = 1'b1;
    exp_pc = 32'h0; exp_instret = 32'h0;
    @(negedge clk);
  endtask

  // One full fetch with nr/nw/nh stall cycles in ISSUE/WAIT/HOLD.
  // spur drives a bogus response in ISSUE (including the accept cycle) and HOLD.
  task automatic serve(input logic [31:0] data, input int nr, input int nw, input int nh,
                       input logic src, input logic [31:0] tgt, input bit spur);
    for (int i = 0; i <= nr; i++) begin
      bus0.imem_req_ready = (i == nr);
      bus0.imem_rsp_valid = spur; bus0.imem_rsp_data = 32'hDEAD_BEEF;
      chk("issue_req", bus0.imem_req_valid, 1);
      chk("issue_addr", bus0.imem_addr, exp_pc);
      chk("issue_ivalid", instr_valid, 0);
      @(negedge clk);
    end
    bus0.imem_req_ready = 1'b0; bus0.imem_rsp_valid = 1'b0;
    for (int i = 0; i <= nw; i++) begin
      bus0.imem_rsp_valid = (i == nw); bus0.imem_rsp_data = data;
      chk("wait_req", bus0.imem_req_valid, 0);
      chk("wait_ivalid", instr_valid, 0);
      chk("wait_instr", instr, NOP);
      @(negedge clk);
    end
    for (int i = 0; i <= nh; i++) begin
      bus0.imem_rsp_valid = spur; bus0.imem_rsp_data = 32'hDEAD_BEEF;
      instr_ready = (i == nh);
      pc_src      = (i == nh) ? src : 1'b1;
      pc_target   = (i == nh) ? tgt : 32'h0000_0F00;
      chk("hold_ivalid", instr_valid, 1);
      chk("hold_instr", instr, data);
      chk("hold_ipc", instr_pc, exp_pc);
      chk("hold_op", op, {25'h0, data[6:0]});
      chk("hold_instret", instret, exp_instret);
      chk("hold_req", bus0.imem_req_valid, 0);
      @(negedge clk);
    end
    instr_ready = 1'b0; pc_src = 1'b0; bus0.imem_rsp_valid = 1'b0;
    $display("txn pc=%08h instr=%08h instret=%0d", exp_pc, data, exp_instret + 32'd1);
    exp_pc = src ? (tgt & ~32'h3) : exp_pc + 32'd4;
    exp_instret = exp_instret + 32'd1;
    chk("ret_instret", instret, exp_instret);
    chk("ret_ivalid", instr_valid, 0);
    chk("ret_instr", instr, NOP);
    chk("ret_op", op, 32'h13);
    chk("ret_req", bus0.imem_req_valid, 1);
    chk("ret_addr", bus0.imem_addr, exp_pc);
  endtask

  initial begin
    bit          pending, model_valid, deliver, accept, retire;
    int          delay;
    rst1_n = 1'b0;
    bus1.imem_req_ready = 1'b0; bus1.imem_rsp_valid = 1'b0; bus1.imem_rsp_data = 32'h0;
    instr_ready1 = 1'b0; pc_src1 = 1'b0; pc_target1 = 32'h0;

    // Basic fetch, memory ready at once and answering next cycle.
    do_reset0();
    serve(32'h0050_0093, 0, 0, 0, 1'b0, 32'h0, 1'b0);
    serve(32'h00A0_0113, 0, 0, 0, 1'b0, 32'h0, 1'b0);
    // Backpressure on every handshake, then spurious responses.
    serve(32'h0011_8193, 3, 4, 5, 1'b0, 32'h0, 1'b0);
    serve(32'h0022_0213, 2, 1, 2, 1'b0, 32'h0, 1'b1);
    // At pc 0x10: pc_src held high while stalled, then taken with unaligned target.
    serve(32'h0000_0063, 0, 0, 2, 1'b1, 32'h0000_0102, 1'b0);

    // Reset during WAIT; response delivered in the BOOT cycle is ignored.
    bus0.imem_req_ready = 1'b1; @(negedge clk);
    bus0.imem_req_ready = 1'b0;
    rst_n = 1'b0; @(negedge clk);
    rst_n = 1'b1; bus0.imem_rsp_valid = 1'b1; bus0.imem_rsp_data = 32'hDEAD_BEEF;
    chk("mrst_ivalid", instr_valid, 0);
    chk("mrst_instret", instret, 0);
    chk("mrst_req", bus0.imem_req_valid, 0);
    chk("mrst_addr", bus0.imem_addr, 0);
    @(negedge clk);
    bus0.imem_rsp_valid = 1'b0;
    chk("mrst_ivalid2", instr_valid, 0);
    chk("mrst_instr", instr, NOP);
    chk("mrst_req2", bus0.imem_req_valid, 1);
    chk("mrst_addr2", bus0.imem_addr, 0);
    exp_pc = 32'h0; exp_instret = 32'h0;

    // Same point 0x10 but not taken.
    for (int k = 0; k < 4; k++) serve(mem_word(exp_pc), 0, 0, 0, 1'b0, 32'h0, 1'b0);
    serve(32'h0000_0063, 0, 0, 0, 1'b0, 32'h0000_0102, 1'b0);

    // Retirement counter wrap.
    force dut0.instret_reg = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut0.instret_reg;
    exp_instret = 32'hFFFF_FFFF;
    serve(mem_word(exp_pc), 0, 0, 1, 1'b0, 32'h0, 1'b0);

    // Randomized run against a transaction-level model of memory and retirement.
    do_reset0();
    pending = 1'b0; model_valid = 1'b0; delay = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      chk("rnd_ivalid", instr_valid, model_valid);
      chk("rnd_req", bus0.imem_req_valid, !pending && !model_valid);
      if (!model_valid) chk("rnd_nop", instr, NOP);
      deliver = pending && (delay == 0);
      bus0.imem_req_ready = 1'($urandom_range(0, 1));
      bus0.imem_rsp_valid = deliver || (!pending && ($urandom_range(0, 9) == 0));
      bus0.imem_rsp_data  = deliver ? mem_word(exp_pc) : 32'hDEAD_BEEF;
      instr_ready = ($urandom_range(0, 2) != 0);
      pc_src      = ($urandom_range(0, 3) == 0);
      pc_target   = $urandom;
      accept = bus0.imem_req_valid && bus0.imem_req_ready;
      retire = model_valid && instr_ready;
      if (accept) chk("rnd_addr", bus0.imem_addr, exp_pc);
      if (retire) begin
        chk("rnd_instr", instr, mem_word(exp_pc));
        chk("rnd_ipc", instr_pc, exp_pc);
        chk("rnd_instret", instret, exp_instret);
        $display("txn pc=%08h instr=%08h instret=%0d", exp_pc, mem_word(exp_pc), exp_instret + 32'd1);
        exp_pc = pc_src ? (pc_target & ~32'h3) : exp_pc + 32'd4;
        exp_instret = exp_instret + 32'd1;
      end
      @(negedge clk);
      if (deliver) begin
        pending = 1'b0; model_valid = 1'b1;
      end else if (pending) begin
        delay--;
      end
      if (accept) begin
        pending = 1'b1; delay = int'($urandom_range(0, 3));
      end
      if (retire) model_valid = 1'b0;
    end
    bus0.imem_rsp_valid = 1'b0; instr_ready = 1'b0;
    chk("rnd_final_instret", instret, exp_instret);

    // PC wrap from 0xFFFF_FFFC on a second instance.
    @(negedge clk);
    rst1_n = 1'b1; @(negedge clk);
    chk("wrap_addr0", bus1.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_req0", bus1.imem_req_valid, 1);
    bus1.imem_req_ready = 1'b1; @(negedge clk);
    bus1.imem_req_ready = 1'b0; bus1.imem_rsp_valid = 1'b1; bus1.imem_rsp_data = 32'h0010_0073;
    @(negedge clk);
    bus1.imem_rsp_valid = 1'b0;
    chk("wrap_instr", instr1, 32'h0010_0073);
    chk("wrap_ipc", instr_pc1, 32'hFFFF_FFFC);
    chk("wrap_op", op1, 32'h73);
    instr_ready1 = 1'b1; pc_target1 = 32'h0000_0400; @(negedge clk);
    instr_ready1 = 1'b0;
    $display("txn pc=fffffffc instr=00100073 instret=1 (wrap instance)");
    chk("wrap_addr1", bus1.imem_addr, 32'h0000_0000);
    chk("wrap_instret", instret1, 1);
    chk("wrap_ivalid", instr_valid1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
